// File: rtl/bit_packer.sv
// Packs 1..15-bit LSB-first chunks into 32-bit words behind a DEPTH-entry FIFO; a completed word is at the head one edge later.
// Producer is held off by full (pushes and flushes are dropped while it is high); the consumer pops with pullout.

module bit_packer_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  // Head reads as zero when empty so downstream never sees stale words.
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module bit_packer #(
  parameter int WIDTH        = 32,
  parameter int MAXLEN       = 15,
  parameter int DEPTH        = 4,
  parameter int ADDRESSWIDTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pushin,
  input  logic [3:0]        lenin,
  input  logic [MAXLEN-1:0] datain,
  input  logic              flushin,
  output logic              full,
  output logic              pushout,
  input  logic              pullout,
  output logic [WIDTH-1:0]  dataout,
  output logic [5:0]        lenout
);
  localparam int ACCW = WIDTH + MAXLEN;

  logic [ACCW-1:0]   acc;
  logic [ACCW-1:0]   acc_merged;
  logic [4:0]        cnt;
  logic [5:0]        sum;
  logic [MAXLEN-1:0] mask;
  logic              push_ok;
  logic              flush_ok;
  logic              word_done;
  logic              wr;
  logic [WIDTH+5:0]  wdata;
  logic              empty;

  always_comb begin
    mask       = {MAXLEN{1'b1}} >> (4'(MAXLEN) - lenin);
    acc_merged = acc | (ACCW'(datain & mask) << cnt);
    sum        = {1'b0, cnt} + {2'b00, lenin};
    push_ok    = pushin && !full && (lenin != 4'd0);
    // A simultaneous push wins over a flush.
    flush_ok   = flushin && !pushin && !full && (cnt != 5'd0);
    word_done  = push_ok && (sum >= 6'(WIDTH));
    wr         = word_done || flush_ok;
    // Bits above cnt are always zero in acc, so a flush is already zero-padded.
    wdata      = flush_ok ? {1'b0, cnt, acc[WIDTH-1:0]}
                          : {6'(WIDTH), acc_merged[WIDTH-1:0]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (push_ok) begin
      if (word_done) begin
        acc <= acc_merged >> WIDTH;
        cnt <= 5'(sum - 6'(WIDTH));
      end else begin
        acc <= acc_merged;
        cnt <= sum[4:0];
      end
    end else if (flush_ok) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  bit_packer_fifo #(
    .W     (WIDTH + 6),
    .DEPTH (DEPTH),
    .AW    (ADDRESSWIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr    (wr),
    .wdata (wdata),
    .rd    (pullout),
    .rdata ({lenout, dataout}),
    .empty (empty),
    .full  (full)
  );

  assign pushout = !empty;
endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: bit-queue reference model feeds a scoreboard; a negedge monitor checks the FIFO head.
module tb_bit_packer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        full;
  logic        pushout;
  logic        pullout;
  logic [31:0] dataout;
  logic [5:0]  lenout;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  l;
  } ent_t;

  ent_t sb[$];
  bit   pending[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;

  bit_packer dut (
    .clock   (clock),
    .reset   (reset),
    .pushin  (pushin),
    .lenin   (lenin),
    .datain  (datain),
    .flushin (flushin),
    .full    (full),
    .pushout (pushout),
    .pullout (pullout),
    .dataout (dataout),
    .lenout  (lenout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT head against the scoreboard, pops on consumer pulls.
  always @(negedge clock) begin
    if (mon_en) begin
      ent_t h;
      h.w = 32'd0;
      h.l = 6'd0;
      if (sb.size() > 0) h = sb[0];
      check("mon pushout", 32'(pushout), 32'(sb.size() > 0));
      check("mon full", 32'(full), 32'(sb.size() == DEPTH));
      check("mon dataout", dataout, h.w);
      check("mon lenout", 32'(lenout), 32'(h.l));
      if (pullout && sb.size() > 0) void'(sb.pop_front());
    end
  end

  task automatic take_word(input int n, output ent_t e);
    e.w = 32'd0;
    e.l = 6'(n);
    for (int i = 0; i < n; i++) e.w[i] = pending.pop_front();
  endtask

  // One clock cycle of stimulus; the model decides acceptance from its own occupancy.
  task automatic cyc(input bit p, input int len, input logic [14:0] d, input bit fl, input bit pl);
    bit   f;
    bit   have;
    ent_t e;
    pushin  = p;
    lenin   = 4'(len);
    datain  = d;
    flushin = fl;
    pullout = pl;
    f    = (sb.size() == DEPTH);
    have = 1'b0;
    if (p && !f && len != 0) begin
      for (int i = 0; i < len; i++) pending.push_back(d[i]);
      if (pending.size() >= 32) begin
        take_word(32, e);
        have = 1'b1;
      end
    end else if (fl && !p && !f && pending.size() != 0) begin
      take_word(pending.size(), e);
      have = 1'b1;
    end
    @(posedge clock);
    #1;
    if (have) sb.push_back(e);
    pushin  = 1'b0;
    flushin = 1'b0;
    pullout = 1'b0;
    lenin   = 4'd0;
    datain  = 15'd0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    pushin  = 1'b0;
    flushin = 1'b0;
    pullout = 1'b0;
    lenin   = 4'd0;
    datain  = 15'd0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    pending.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && sb.size() > 0; k++) cyc(0, 0, 15'd0, 0, 1);
    check("drain pushout", 32'(pushout), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    do_reset();
    check("reset pushout", 32'(pushout), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset dataout", dataout, 32'd0);
    check("reset lenout", 32'(lenout), 32'd0);
    mon_en = 1'b1;

    // Basic pack
    for (int i = 1; i <= 8; i++) cyc(1, 4, 15'(i), 0, 0);
    check("basic pushout", 32'(pushout), 32'd1);
    check("basic dataout", dataout, 32'h87654321);
    check("basic lenout", 32'(lenout), 32'd32);
    check("basic full", 32'(full), 32'd0);
    cyc(0, 0, 15'd0, 0, 1);
    check("basic one word", 32'(pushout), 32'd0);

    // Straddle and flush
    for (int i = 0; i < 3; i++) cyc(1, 15, 15'h7FFF, 0, 0);
    check("straddle dataout", dataout, 32'hFFFFFFFF);
    check("straddle lenout", 32'(lenout), 32'd32);
    cyc(0, 0, 15'd0, 1, 0);
    cyc(0, 0, 15'd0, 0, 1);
    check("flush dataout", dataout, 32'h00001FFF);
    check("flush lenout", 32'(lenout), 32'd13);
    cyc(0, 0, 15'd0, 0, 1);
    check("flush popped", 32'(pushout), 32'd0);

    // Masking and zero-length no-op
    cyc(1, 2, 15'h7FFD, 0, 0);
    cyc(1, 0, 15'h7FFF, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 2, 15'd0, 0, 0);
    check("mask dataout", dataout, 32'h00000001);
    check("mask lenout", 32'(lenout), 32'd32);
    drain();

    // Backpressure
    for (int i = 0; i < 32; i++) cyc(1, 4, 15'(i % 15), 0, 0);
    check("bp full", 32'(full), 32'd1);
    cyc(1, 4, 15'hF, 0, 0);
    check("bp still full", 32'(full), 32'd1);
    cyc(0, 0, 15'd0, 0, 1);
    check("bp full drops", 32'(full), 32'd0);
    drain();
    cyc(0, 0, 15'd0, 1, 0);
    check("bp dropped push left no bits", 32'(pushout), 32'd0);

    // Flush corner cases
    cyc(0, 0, 15'd0, 1, 0);
    check("flush empty", 32'(pushout), 32'd0);
    cyc(1, 4, 15'hA, 1, 0);
    check("flush+push", 32'(pushout), 32'd0);
    cyc(0, 0, 15'd0, 1, 0);
    check("flush A dataout", dataout, 32'h0000000A);
    check("flush A lenout", 32'(lenout), 32'd4);
    drain();

    // Reset mid-operation
    for (int i = 0; i < 21; i++) cyc(1, 4, 15'($urandom), 0, 0);
    check("pre-reset pushout", 32'(pushout), 32'd1);
    do_reset();
    check("mid reset pushout", 32'(pushout), 32'd0);
    check("mid reset full", 32'(full), 32'd0);
    check("mid reset dataout", dataout, 32'd0);
    check("mid reset lenout", 32'(lenout), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1, 4, 15'h1, 0, 0);
    check("post reset dataout", dataout, 32'h11111111);
    check("post reset lenout", 32'(lenout), 32'd32);
    drain();

    // Randomized traffic with alternating consumer pressure
    for (int i = 0; i < 3000; i++) begin
      bit pl;
      if (((i / 200) % 2) == 1) pl = ($urandom_range(0, 3) == 0);
      else                      pl = ($urandom_range(0, 5) != 0);
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), 15'($urandom),
          $urandom_range(0, 9) == 0, pl);
    end
    drain();
    cyc(0, 0, 15'd0, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
